// File: rtl/hdmi_line_fetch_ctrl.sv
// Purpose : turns each line_request into Avalon-MM burst reads from the front frame buffer and
//           streams the words out as one Avalon-ST packet per video line.
// Latency : avm_read_o 1 cycle after line_request_i; aso_* 1 cycle after each readdatavalid beat.
// Backpr. : none downstream (sink must take every word); upstream stalls only via avm_waitrequest_i.
//
// Ports
//   clk, reset_n                      system clock, async active-low reset
//   frame_start_i                     frame boundary pulse (front buffer swap, line counter reset)
//   line_request_i                    fetch the next line
//   wr_frame_done_i, wr_buf_i         writer completed buffer wr_buf_i
//   frame_buffer_ready_o              at least one complete frame has been written
//   avm_*                             Avalon-MM burst read master
//   aso_*                             Avalon-ST source, one packet per line
//   overrun_o                         sticky: line request seen while a line was in flight
//   line_cnt_o                        line being fetched / next line to fetch
module hdmi_line_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LINE_WORDS = 1280,
  parameter int                    LINES      = 720,
  parameter int                    BURST_LEN  = 64,
  parameter logic [ADDR_WIDTH-1:0] BUF0_BASE  = 'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] BUF1_BASE  = 'h0040_0000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_start_i,
  input  logic                          line_request_i,
  input  logic                          wr_frame_done_i,
  input  logic                          wr_buf_i,
  output logic                          frame_buffer_ready_o,
  output logic [ADDR_WIDTH-1:0]         avm_address_o,
  output logic                          avm_read_o,
  output logic [$clog2(BURST_LEN):0]    avm_burstcount_o,
  input  logic                          avm_waitrequest_i,
  input  logic [DATA_WIDTH-1:0]         avm_readdata_i,
  input  logic                          avm_readdatavalid_i,
  output logic                          aso_valid_o,
  output logic [DATA_WIDTH-1:0]         aso_data_o,
  output logic                          aso_startofpacket_o,
  output logic                          aso_endofpacket_o,
  output logic                          overrun_o,
  output logic [$clog2(LINES)-1:0]      line_cnt_o
);

  localparam int BCW   = $clog2(BURST_LEN) + 1;
  localparam int BW    = $clog2(BURST_LEN);
  localparam int WIW   = $clog2(LINE_WORDS + 1);
  localparam int LCW   = $clog2(LINES);
  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state;
  logic            front_buf;
  logic            pending_buf;
  logic            fs_pend;      // frame_start seen while busy, applied on the way back to IDLE
  logic            frame_ready;
  logic            overrun;
  logic [LCW-1:0]  line_cnt;
  logic [WIW-1:0]  word_idx;     // line word index of the current burst's first word
  logic [BW-1:0]   beat_cnt;

  logic                  pend_nxt;
  logic                  beat_fire;
  logic                  last_beat;
  logic                  last_burst;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [ADDR_WIDTH-1:0] base_addr;

  // A writer completion in the same cycle as frame_start wins over the stored pending index.
  assign pend_nxt   = wr_frame_done_i ? wr_buf_i : pending_buf;
  assign beat_fire  = (state == DATA) && avm_readdatavalid_i;
  assign last_beat  = beat_fire && (beat_cnt == BW'(BURST_LEN - 1));
  assign last_burst = (word_idx + WIW'(BURST_LEN)) == WIW'(LINE_WORDS);

  // front_buf and line_cnt cannot change outside IDLE/DONE, so the address is stable through REQ.
  assign word_off  = ADDR_WIDTH'(line_cnt) * ADDR_WIDTH'(LINE_WORDS) + ADDR_WIDTH'(word_idx);
  assign base_addr = front_buf ? BUF1_BASE : BUF0_BASE;

  assign avm_read_o           = (state == REQ);
  assign avm_address_o        = (state == REQ) ? base_addr + word_off * ADDR_WIDTH'(BYTES) : '0;
  assign avm_burstcount_o     = (state == REQ) ? BCW'(BURST_LEN) : '0;
  assign frame_buffer_ready_o = frame_ready;
  assign overrun_o            = overrun;
  assign line_cnt_o           = line_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      front_buf           <= 1'b0;
      pending_buf         <= 1'b0;
      fs_pend             <= 1'b0;
      frame_ready         <= 1'b0;
      overrun             <= 1'b0;
      line_cnt            <= '0;
      word_idx            <= '0;
      beat_cnt            <= '0;
      aso_valid_o         <= 1'b0;
      aso_data_o          <= '0;
      aso_startofpacket_o <= 1'b0;
      aso_endofpacket_o   <= 1'b0;
    end else begin
      if (wr_frame_done_i) begin
        pending_buf <= wr_buf_i;
        frame_ready <= 1'b1;
      end

      if (line_request_i && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      if (frame_start_i && ((state == REQ) || (state == DATA))) begin
        fs_pend <= 1'b1;
      end

      // Stream side: beats outside DATA (e.g. stragglers after a reset) are dropped here.
      aso_valid_o         <= beat_fire;
      aso_startofpacket_o <= beat_fire && (word_idx == '0) && (beat_cnt == '0);
      aso_endofpacket_o   <= beat_fire && ((word_idx + WIW'(beat_cnt)) == WIW'(LINE_WORDS - 1));
      if (beat_fire) begin
        aso_data_o <= avm_readdata_i;
      end

      case (state)
        IDLE: begin
          if (frame_start_i) begin
            line_cnt  <= '0;
            front_buf <= pend_nxt;
          end
          if (line_request_i && frame_ready) begin
            word_idx <= '0;
            beat_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (!avm_waitrequest_i) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
          if (last_beat) begin
            beat_cnt <= '0;
            if (last_burst) begin
              word_idx <= '0;
              state    <= DONE;
            end else begin
              word_idx <= word_idx + WIW'(BURST_LEN);
              state    <= REQ;
            end
          end
        end
        default: begin  // DONE
          if (frame_start_i || fs_pend) begin
            line_cnt  <= '0;
            front_buf <= pend_nxt;
            fs_pend   <= 1'b0;
          end else begin
            line_cnt <= (line_cnt == LCW'(LINES - 1)) ? '0 : line_cnt + LCW'(1);
          end
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Purpose : scoreboard bench for hdmi_line_fetch_ctrl with a randomized Avalon-MM slave.
// Latency : expectations are queued at request time and consumed whenever aso_valid_o is seen.
// Backpr. : the slave model inserts waitrequest cycles and readdatavalid gaps.
module tb_hdmi_line_fetch_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LW  = 64;
  localparam int NL  = 5;
  localparam int BL  = 16;
  localparam int NB  = LW / BL;
  localparam int BCW = $clog2(BL) + 1;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0040_0000;

  logic                   clk;
  logic                   reset_n;
  logic                   frame_start_i;
  logic                   line_request_i;
  logic                   wr_frame_done_i;
  logic                   wr_buf_i;
  logic                   frame_buffer_ready_o;
  logic [AW-1:0]          avm_address_o;
  logic                   avm_read_o;
  logic [BCW-1:0]         avm_burstcount_o;
  logic                   avm_waitrequest_i;
  logic [DW-1:0]          avm_readdata_i;
  logic                   avm_readdatavalid_i;
  logic                   aso_valid_o;
  logic [DW-1:0]          aso_data_o;
  logic                   aso_startofpacket_o;
  logic                   aso_endofpacket_o;
  logic                   overrun_o;
  logic [$clog2(NL)-1:0]  line_cnt_o;

  hdmi_line_fetch_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW), .LINES(NL), .BURST_LEN(BL),
    .BUF0_BASE(B0), .BUF1_BASE(B1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .frame_start_i(frame_start_i), .line_request_i(line_request_i),
    .wr_frame_done_i(wr_frame_done_i), .wr_buf_i(wr_buf_i),
    .frame_buffer_ready_o(frame_buffer_ready_o),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o),
    .avm_burstcount_o(avm_burstcount_o), .avm_waitrequest_i(avm_waitrequest_i),
    .avm_readdata_i(avm_readdata_i), .avm_readdatavalid_i(avm_readdatavalid_i),
    .aso_valid_o(aso_valid_o), .aso_data_o(aso_data_o),
    .aso_startofpacket_o(aso_startofpacket_o), .aso_endofpacket_o(aso_endofpacket_o),
    .overrun_o(overrun_o), .line_cnt_o(line_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_burst_q[$];
  logic [31:0] slv_q[$];

  int n_checks = 0;
  int n_errs   = 0;
  int wait_mode = 0;      // 0: none, 1: random 0..3, 2: 5 cycles on the third burst of a line
  int gap_mode  = 0;      // 0: back-to-back beats, 1: random gaps
  int burst_idx = 0;
  int bursts_seen = 0;
  int beats_seen  = 0;
  int waited_cycles = 0;

  // Reference model of the frame/line bookkeeping.
  bit m_ready, m_front, m_pending, m_fs_pend, m_overrun;
  int m_line;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s", name);
  endtask

  // Avalon-MM slave: returns the word byte address as read data.
  initial begin
    bit          in_burst = 0;
    int          wait_left = 0;
    logic [31:0] hold_addr = '0;
    avm_waitrequest_i   = 1'b0;
    avm_readdatavalid_i = 1'b0;
    avm_readdata_i      = '0;
    forever begin
      @(posedge clk); #1;
      if (slv_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
        avm_readdatavalid_i = 1'b1;
        avm_readdata_i      = slv_q.pop_front();
      end else begin
        avm_readdatavalid_i = 1'b0;
        avm_readdata_i      = $urandom;
      end
      if (!avm_read_o) begin
        in_burst          = 0;
        avm_waitrequest_i = 1'b0;
      end else begin
        if (!in_burst) begin
          in_burst  = 1;
          hold_addr = avm_address_o;
          if (wait_mode == 1)      wait_left = $urandom_range(0, 3);
          else if (wait_mode == 2) wait_left = (burst_idx % NB == 2) ? 5 : 0;
          else                     wait_left = 0;
        end else begin
          chk("hold_addr", 64'(avm_address_o), 64'(hold_addr));
        end
        chk("burstcount", 64'(avm_burstcount_o), 64'(BL));
        if (wait_left > 0) begin
          avm_waitrequest_i = 1'b1;
          wait_left--;
          waited_cycles++;
        end else begin
          avm_waitrequest_i = 1'b0;
          if (exp_burst_q.size() == 0) fail_now("unexpected_burst");
          else chk("burst_addr", 64'(avm_address_o), 64'(exp_burst_q.pop_front()));
          for (int i = 0; i < BL; i++) slv_q.push_back(avm_address_o + 32'(4 * i));
          burst_idx++;
          bursts_seen++;
          in_burst = 0;
        end
      end
    end
  end

  // Stream monitor.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset_n && aso_valid_o) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          chk("aso_data", 64'(aso_data_o), 64'(e.dat));
          chk("aso_sop", 64'(aso_startofpacket_o), 64'(e.sop));
          chk("aso_eop", 64'(aso_endofpacket_o), 64'(e.eop));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic pulse(input bit fs, input bit lr, input bit wfd, input bit wb);
    @(posedge clk); #1;
    frame_start_i = fs; line_request_i = lr; wr_frame_done_i = wfd; wr_buf_i = wb;
    @(posedge clk); #1;
    frame_start_i = 0; line_request_i = 0; wr_frame_done_i = 0; wr_buf_i = 0;
  endtask

  task automatic push_line();
    logic [31:0] base;
    beat_t b;
    base = m_front ? B1 : B0;
    for (int k = 0; k < NB; k++) exp_burst_q.push_back(base + 32'((m_line * LW + k * BL) * 4));
    for (int i = 0; i < LW; i++) begin
      b.dat = base + 32'((m_line * LW + i) * 4);
      b.sop = (i == 0);
      b.eop = (i == LW - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"},  64'(frame_buffer_ready_o), 64'(0));
    chk({tag, "_addr"},   64'(avm_address_o), 64'(0));
    chk({tag, "_read"},   64'(avm_read_o), 64'(0));
    chk({tag, "_bcnt"},   64'(avm_burstcount_o), 64'(0));
    chk({tag, "_valid"},  64'(aso_valid_o), 64'(0));
    chk({tag, "_data"},   64'(aso_data_o), 64'(0));
    chk({tag, "_sop"},    64'(aso_startofpacket_o), 64'(0));
    chk({tag, "_eop"},    64'(aso_endofpacket_o), 64'(0));
    chk({tag, "_ovr"},    64'(overrun_o), 64'(0));
    chk({tag, "_line"},   64'(line_cnt_o), 64'(0));
  endtask

  // One full line fetch; optional events injected while the line is in flight.
  task automatic run_line(input bit mid_fs, input bit mid_wfd, input bit mid_wb, input bit mid_req);
    int sb, sr, cyc;
    sb = beats_seen;
    sr = bursts_seen;
    push_line();
    pulse(0, 1, 0, 0);
    if (mid_fs || mid_wfd || mid_req) begin
      cyc = 0;
      while (cyc < 1000 && beats_seen < sb + 3) begin @(negedge clk); cyc++; end
      if (beats_seen < sb + 3) fail_now("mid_line_wait");
      pulse(mid_fs, mid_req, mid_wfd, mid_wb);
      if (mid_wfd) begin m_pending = mid_wb; m_ready = 1; end
      if (mid_fs) m_fs_pend = 1;
      if (mid_req) m_overrun = 1;
    end
    cyc = 0;
    while (cyc < 3000 && exp_q.size() != 0) begin @(negedge clk); cyc++; end
    if (exp_q.size() != 0) begin
      fail_now("line_complete_wait");
      exp_q.delete();
      exp_burst_q.delete();
    end
    repeat (3) @(negedge clk);
    if (m_fs_pend) begin
      m_front = m_pending; m_line = 0; m_fs_pend = 0;
    end else begin
      m_line = (m_line == NL - 1) ? 0 : m_line + 1;
    end
    chk("line_cnt", 64'(line_cnt_o), 64'(m_line));
    chk("bursts_per_line", 64'(bursts_seen - sr), 64'(NB));
    chk("beats_per_line", 64'(beats_seen - sb), 64'(LW));
    chk("overrun", 64'(overrun_o), 64'(m_overrun));
    chk("frame_ready", 64'(frame_buffer_ready_o), 64'(m_ready));
  endtask

  initial begin
    bit saw_read;
    int w0, bb, cyc;
    bit rf, rw, rb, rq;
    frame_start_i = 0; line_request_i = 0; wr_frame_done_i = 0; wr_buf_i = 0;
    reset_n = 0;
    m_ready = 0; m_front = 0; m_pending = 0; m_fs_pend = 0; m_overrun = 0; m_line = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1;

    // No finished frame yet: request is ignored without overrun.
    pulse(0, 1, 0, 0);
    saw_read = 0;
    repeat (10) begin @(negedge clk); if (avm_read_o) saw_read = 1; end
    chk("noframe_read", 64'(saw_read), 64'(0));
    chk("noframe_ready", 64'(frame_buffer_ready_o), 64'(0));
    chk("noframe_ovr", 64'(overrun_o), 64'(0));

    // First frame in buffer 1, zero-wait slave.
    pulse(0, 0, 1, 1); m_pending = 1; m_ready = 1;
    pulse(1, 0, 0, 0); m_front = m_pending; m_line = 0;
    run_line(0, 0, 0, 0);
    chk("first_line_cnt", 64'(line_cnt_o), 64'(1));

    // Long waitrequest on the third burst.
    wait_mode = 2;
    w0 = waited_cycles;
    run_line(0, 0, 0, 0);
    chk("waited_cycles", 64'(waited_cycles - w0), 64'(5));
    wait_mode = 0;

    // Overrun is sticky and does not disturb the line in flight.
    run_line(0, 0, 0, 1);
    run_line(0, 0, 0, 0);

    // Writer finishes buffer 0 mid-frame; swap only at the next frame start.
    run_line(0, 1, 0, 0);
    run_line(0, 0, 0, 0);
    pulse(1, 0, 0, 0); m_front = m_pending; m_line = 0;
    run_line(0, 0, 0, 0);

    // Frame start while busy, with a writer completion in the same cycle: deferred swap.
    run_line(1, 1, 1, 0);
    run_line(0, 0, 0, 0);

    // Wrap through a whole frame, then randomized traffic.
    gap_mode = 1;
    wait_mode = 1;
    for (int k = 0; k < NL + 1; k++) run_line(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        rb = 1'($urandom_range(0, 1));
        pulse(1, 0, 1, rb);
        m_pending = rb; m_ready = 1; m_front = rb; m_line = 0;
      end
      rf = ($urandom_range(0, 4) == 0);
      rw = ($urandom_range(0, 3) == 0);
      rb = 1'($urandom_range(0, 1));
      rq = ($urandom_range(0, 3) == 0);
      run_line(rf, rw, rb, rq);
    end

    // Reset in the middle of a burst; stragglers must not reach the stream.
    gap_mode = 0;
    wait_mode = 0;
    bb = beats_seen;
    push_line();
    pulse(0, 1, 0, 0);
    cyc = 0;
    while (cyc < 1000 && beats_seen < bb + 20) begin @(negedge clk); cyc++; end
    if (beats_seen < bb + 20) fail_now("reset_mid_wait");
    @(posedge clk); #2;
    reset_n = 0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    exp_burst_q.delete();
    m_ready = 0; m_front = 0; m_pending = 0; m_fs_pend = 0; m_overrun = 0; m_line = 0;
    burst_idx = 0;
    bb = beats_seen;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1;
    saw_read = 0;
    repeat (25) begin @(negedge clk); if (avm_read_o || aso_valid_o) saw_read = 1; end
    chk("late_beats_dropped", 64'(saw_read), 64'(0));
    chk("late_beat_count", 64'(beats_seen - bb), 64'(0));
    chk("slave_drained", 64'(slv_q.size()), 64'(0));

    // Recovery after reset.
    pulse(0, 0, 1, 0); m_pending = 0; m_ready = 1;
    pulse(1, 0, 0, 0); m_front = 0; m_line = 0;
    run_line(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
